bpred_unit: RTL and testbench

BPRED_UNIT -- requirements
Module: bpred_unit

---
 rtl/bpred_pkg.sv | 37 +++
 rtl/bpred_ras.sv | 62 ++++++
 rtl/bpred_unit.sv | 208 ++++++++++++++++++++
 tb/tb_bpred_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bpred_pkg.sv
// ---------------------------------------------------------------------------
// bpred_pkg : shared types and helpers for the branch predictor slice
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bpred_pkg;

  // Entry fields are sized for the widest supported build; narrower builds
  // zero-extend into them and synthesis trims the constant bits.
  localparam int unsigned XLEN_MAX  = 64;
  localparam int unsigned CTR_W_MAX = 4;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bpred_state_e;

  typedef struct packed {
    logic                 valid;
    logic [XLEN_MAX-1:0]  tag;
    logic [CTR_W_MAX-1:0] ctr;
    logic [XLEN_MAX-1:0]  target;
  } bpred_entry_t;

  // Weakly not-taken: 2^(ctr_w-1)-1
  function automatic logic [CTR_W_MAX-1:0] ctr_weak_nt(input int unsigned ctr_w);
    return CTR_W_MAX'((32'd1 << (ctr_w - 32'd1)) - 32'd1);
  endfunction

  function automatic logic [CTR_W_MAX-1:0] ctr_sat_max(input int unsigned ctr_w);
    return CTR_W_MAX'((32'd1 << ctr_w) - 32'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bpred_ras.sv
// ---------------------------------------------------------------------------
// bpred_ras : circular return-address stack, oldest entry lost on overflow
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bpred_ras #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] push_data_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  stack_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, w_ptr_pop;
  logic [CNT_W-1:0] cnt_q, cnt_d, w_cnt_pop;
  logic             w_pop;

  assign empty_o = (cnt_q == '0);
  assign w_pop   = pop_i & ~empty_o;
  assign top_o   = stack_q[ptr_q - PTR_W'(1)];

  // Pop is applied first so a same-cycle call/ret replaces the top slot.
  always_comb begin
    w_ptr_pop = w_pop ? (ptr_q - PTR_W'(1)) : ptr_q;
    w_cnt_pop = w_pop ? (cnt_q - CNT_W'(1)) : cnt_q;
    ptr_d     = w_ptr_pop;
    cnt_d     = w_cnt_pop;
    if (push_i) begin
      ptr_d = w_ptr_pop + PTR_W'(1);
      cnt_d = (w_cnt_pop == CNT_W'(RAS_DEPTH)) ? w_cnt_pop : (w_cnt_pop + CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && push_i) begin
      stack_q[w_ptr_pop] <= push_data_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bpred_unit.sv
// ---------------------------------------------------------------------------
// bpred_unit : direct-mapped tagged bimodal predictor with optional RAS
// Optional return stack built only when BPRED_RAS_EN is defined.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bpred_unit
  import bpred_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ENTRIES   = 256,
  parameter int unsigned CTR_W     = 2,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            lk_valid,
  input  logic [XLEN-1:0] lk_pc,
  input  logic            lk_is_jump,
  input  logic            lk_is_call,
  input  logic            lk_is_ret,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            up_valid,
  input  logic [XLEN-1:0] up_pc,
  input  logic            up_taken,
  input  logic [XLEN-1:0] up_target,
  input  logic            up_mispredict,
  output logic            init_busy,
  output logic [31:0]     perf_lookups,
  output logic [31:0]     perf_mispred
);

  localparam int unsigned          IDX_W      = $clog2(ENTRIES);
  localparam logic [CTR_W_MAX-1:0] C_CTR_INIT = ctr_weak_nt(CTR_W);
  localparam logic [CTR_W_MAX-1:0] C_CTR_MAX  = ctr_sat_max(CTR_W);

  bpred_state_e     state_q;
  logic             init_busy_q;
  logic [IDX_W-1:0] init_idx_q;
  logic [31:0]      perf_lk_q, perf_lk_d;
  logic [31:0]      perf_mp_q, perf_mp_d;
  bpred_entry_t     table_q [ENTRIES];

  logic             w_run;
  logic [XLEN-1:0]  w_fall;

  assign w_run  = (state_q == ST_RUN);
  assign w_fall = lk_pc + XLEN'(1);

  // ------------------------------------------------------------ lookup
  logic [IDX_W-1:0] w_lk_idx;
  bpred_entry_t     w_lk_ent;
  logic             w_lk_hit;
  logic             w_lk_jump;
  logic             w_tbl_taken;
  logic [XLEN-1:0]  w_tbl_target;

  assign w_lk_idx     = lk_pc[IDX_W-1:0];
  assign w_lk_ent     = table_q[w_lk_idx];
  assign w_lk_hit     = w_lk_ent.valid && (w_lk_ent.tag == XLEN_MAX'(lk_pc[XLEN-1:IDX_W]));
  assign w_lk_jump    = lk_valid & lk_is_jump;
  assign w_tbl_taken  = w_run & w_lk_jump & w_lk_hit & w_lk_ent.ctr[CTR_W-1];
  assign w_tbl_target = XLEN'(w_lk_ent.target);

`ifdef BPRED_RAS_EN
  logic            w_ras_push;
  logic            w_ras_pop;
  logic            w_ras_empty;
  logic [XLEN-1:0] w_ras_top;

  assign w_ras_push = w_run & lk_valid & lk_is_call;
  assign w_ras_pop  = w_run & lk_valid & lk_is_ret & ~w_ras_empty;

  bpred_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (w_ras_push),
    .pop_i       (w_ras_pop),
    .push_data_i (w_fall),
    .top_o       (w_ras_top),
    .empty_o     (w_ras_empty)
  );

  always_comb begin
    pred_taken  = w_tbl_taken;
    pred_target = w_tbl_taken ? w_tbl_target : w_fall;
    if (w_ras_pop) begin
      pred_taken  = 1'b1;
      pred_target = w_ras_top;
    end
  end
`else
  logic w_unused_ras;
  assign w_unused_ras = lk_is_call ^ lk_is_ret;

  assign pred_taken  = w_tbl_taken;
  assign pred_target = w_tbl_taken ? w_tbl_target : w_fall;
`endif

  // ------------------------------------------------------------ update
  logic [IDX_W-1:0]     w_up_idx;
  bpred_entry_t         w_up_ent;
  logic [XLEN_MAX-1:0]  w_up_tag;
  logic                 w_up_hit;
  logic [CTR_W_MAX-1:0] w_up_base;
  logic [CTR_W_MAX-1:0] w_up_ctr;

  assign w_up_idx  = up_pc[IDX_W-1:0];
  assign w_up_ent  = table_q[w_up_idx];
  assign w_up_tag  = XLEN_MAX'(up_pc[XLEN-1:IDX_W]);
  assign w_up_hit  = w_up_ent.valid && (w_up_ent.tag == w_up_tag);
  assign w_up_base = w_up_hit ? w_up_ent.ctr : C_CTR_INIT;

  always_comb begin
    w_up_ctr = w_up_base;
    if (up_taken) begin
      if (w_up_base != C_CTR_MAX) w_up_ctr = w_up_base + CTR_W_MAX'(1);
    end else begin
      if (w_up_base != '0) w_up_ctr = w_up_base - CTR_W_MAX'(1);
    end
  end

  // Single write port: clearing owns it during INIT, updates during RUN.
  logic             w_we;
  logic [IDX_W-1:0] w_widx;
  bpred_entry_t     w_wdata;

  always_comb begin
    w_we        = 1'b0;
    w_widx      = init_idx_q;
    w_wdata     = '0;
    w_wdata.ctr = C_CTR_INIT;
    if (!w_run) begin
      w_we = 1'b1;
    end else if (up_valid) begin
      w_we           = 1'b1;
      w_widx         = w_up_idx;
      w_wdata.valid  = 1'b1;
      w_wdata.tag    = w_up_tag;
      w_wdata.ctr    = w_up_ctr;
      w_wdata.target = up_taken ? XLEN_MAX'(up_target) : w_up_ent.target;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && w_we) begin
      table_q[w_widx] <= w_wdata;
    end
  end

  // ------------------------------------------------------------ control
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_INIT;
      init_idx_q  <= '0;
      init_busy_q <= 1'b1;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_idx_q <= init_idx_q + IDX_W'(1);
          if (init_idx_q == IDX_W'(ENTRIES - 1)) begin
            state_q     <= ST_RUN;
            init_busy_q <= 1'b0;
          end
        end
        ST_RUN: begin
          state_q     <= ST_RUN;
          init_busy_q <= 1'b0;
        end
        default: begin
          state_q     <= ST_INIT;
          init_idx_q  <= '0;
          init_busy_q <= 1'b1;
        end
      endcase
    end
  end

  assign init_busy = init_busy_q;

  // ------------------------------------------------------------ perf
  always_comb begin
    perf_lk_d = perf_lk_q;
    perf_mp_d = perf_mp_q;
    if (w_run && w_lk_jump && (perf_lk_q != 32'hFFFF_FFFF)) perf_lk_d = perf_lk_q + 32'd1;
    if (w_run && up_valid && up_mispredict && (perf_mp_q != 32'hFFFF_FFFF)) perf_mp_d = perf_mp_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_lk_q <= '0;
      perf_mp_q <= '0;
    end else begin
      perf_lk_q <= perf_lk_d;
      perf_mp_q <= perf_mp_d;
    end
  end

  assign perf_lookups = perf_lk_q;
  assign perf_mispred = perf_mp_q;

endmodule

`default_nettype wire

// File: tb/tb_bpred_unit.sv
// ---------------------------------------------------------------------------
// tb_bpred_unit : directed + random stimulus against a behavioural model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bpred_unit;

  localparam int XLEN      = 32;
  localparam int ENTRIES   = 256;
  localparam int CTR_W     = 2;
  localparam int RAS_DEPTH = 8;
  localparam int WEAK_NT   = (1 << (CTR_W - 1)) - 1;
  localparam int SAT_MAX   = (1 << CTR_W) - 1;

  logic            clk = 1'b0;
  logic            rstn;
  logic            lk_valid, lk_is_jump, lk_is_call, lk_is_ret;
  logic [XLEN-1:0] lk_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            up_valid, up_taken, up_mispredict;
  logic [XLEN-1:0] up_pc, up_target;
  logic            init_busy;
  logic [31:0]     perf_lookups, perf_mispred;

  bpred_unit #(
    .XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_W(CTR_W), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn),
    .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_is_jump(lk_is_jump),
    .lk_is_call(lk_is_call), .lk_is_ret(lk_is_ret),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .up_valid(up_valid), .up_pc(up_pc), .up_taken(up_taken),
    .up_target(up_target), .up_mispredict(up_mispredict),
    .init_busy(init_busy), .perf_lookups(perf_lookups), .perf_mispred(perf_mispred)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: one record per table slot, a queue for the stack
  bit          m_valid [ENTRIES];
  logic [23:0] m_tag   [ENTRIES];
  int          m_ctr   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  logic [31:0] m_ras   [$];
  int          m_init_left;
  longint      m_plk, m_pmp;
  bit          ras_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_ctr[i]   = WEAK_NT;
      m_tgt[i]   = '0;
    end
  endtask

  // One clock: drive, check combinational prediction and counters, advance model.
  task automatic cyc(input bit lkv, input logic [31:0] lpc, input bit jmp,
                     input bit call, input bit ret,
                     input bit upv, input logic [31:0] upc, input bit upt,
                     input logic [31:0] utgt, input bit umis);
    bit          busy, exp_taken;
    logic [31:0] exp_tgt;
    int          idx, base;
    lk_valid = lkv; lk_pc = lpc; lk_is_jump = jmp; lk_is_call = call; lk_is_ret = ret;
    up_valid = upv; up_pc = upc; up_taken = upt; up_target = utgt; up_mispredict = umis;
    #1;
    busy      = (m_init_left > 0);
    exp_taken = 1'b0;
    exp_tgt   = lpc + 32'd1;
    if (!busy) begin
      idx = int'(lpc % ENTRIES);
      if (lkv && jmp && m_valid[idx] && (m_tag[idx] == lpc / ENTRIES) && (m_ctr[idx] > WEAK_NT)) begin
        exp_taken = 1'b1;
        exp_tgt   = m_tgt[idx];
      end
      if (ras_en && lkv && ret && (m_ras.size() > 0)) begin
        exp_taken = 1'b1;
        exp_tgt   = m_ras[$];
      end
    end
    chk("init_busy",    {31'd0, init_busy},  {31'd0, busy});
    chk("pred_taken",   {31'd0, pred_taken}, {31'd0, exp_taken});
    chk("pred_target",  pred_target,         exp_tgt);
    chk("perf_lookups", perf_lookups,        m_plk[31:0]);
    chk("perf_mispred", perf_mispred,        m_pmp[31:0]);
    @(posedge clk);
    if (busy) begin
      m_init_left--;
    end else begin
      if (ras_en) begin
        if (lkv && ret && (m_ras.size() > 0)) void'(m_ras.pop_back());
        if (lkv && call) begin
          m_ras.push_back(lpc + 32'd1);
          if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
        end
      end
      if (upv) begin
        idx  = int'(upc % ENTRIES);
        base = (m_valid[idx] && (m_tag[idx] == upc / ENTRIES)) ? m_ctr[idx] : WEAK_NT;
        if (upt) begin
          base       = (base + 1 > SAT_MAX) ? SAT_MAX : base + 1;
          m_tgt[idx] = utgt;
        end else begin
          base = (base > 0) ? base - 1 : 0;
        end
        m_ctr[idx]   = base;
        m_valid[idx] = 1'b1;
        m_tag[idx]   = upc[31:8];
      end
      if (lkv && jmp && (m_plk < 64'hFFFF_FFFF)) m_plk++;
      if (upv && umis && (m_pmp < 64'hFFFF_FFFF)) m_pmp++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    lk_valid = 0; lk_pc = '0; lk_is_jump = 0; lk_is_call = 0; lk_is_ret = 0;
    up_valid = 0; up_pc = '0; up_taken = 0; up_target = '0; up_mispredict = 0;
    rstn = 1'b0;
    repeat (n) @(posedge clk);
    m_init_left = ENTRIES;
    m_plk = 0;
    m_pmp = 0;
    m_ras.delete();
    model_clear();
    @(negedge clk);
    chk("rst_busy",    {31'd0, init_busy}, 32'd1);
    chk("rst_perf_lk", perf_lookups,       32'd0);
    chk("rst_perf_mp", perf_mispred,       32'd0);
    rstn = 1'b1;
  endtask

  // Random traffic concentrated on a few slots and tags so hits, aliases and
  // stack activity all occur.
  task automatic rnd_cyc();
    logic [31:0] lpc, upc;
    lpc = ($urandom_range(0, 2) << 8) | (32'h40 + $urandom_range(0, 5));
    upc = ($urandom_range(0, 2) << 8) | (32'h40 + $urandom_range(0, 5));
    cyc($urandom_range(0, 3) != 0, lpc, $urandom_range(0, 1), $urandom_range(0, 4) == 0,
        $urandom_range(0, 4) == 0, $urandom_range(0, 1), upc, $urandom_range(0, 1),
        $urandom, $urandom_range(0, 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ras_en = 1'b0;
`ifdef BPRED_RAS_EN
    ras_en = 1'b1;
`endif
    rstn = 1'b0;
    @(negedge clk);
    do_reset(3);

    // INIT window: random traffic must not predict, train, or count
    for (int i = 0; i < ENTRIES; i++) rnd_cyc();

    // Train taken twice, then weaken step by step
    cyc(0, 32'h0, 0, 0, 0, 1, 32'h40, 1, 32'h10, 1);
    cyc(0, 32'h0, 0, 0, 0, 1, 32'h40, 1, 32'h10, 0);
    cyc(1, 32'h40, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    cyc(0, 32'h0, 0, 0, 0, 1, 32'h40, 0, 32'h0, 1);
    cyc(1, 32'h40, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    cyc(0, 32'h0, 0, 0, 0, 1, 32'h40, 0, 32'h0, 1);
    cyc(1, 32'h40, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0);

    // Alias on slot 0x40 with a different tag
    cyc(0, 32'h0, 0, 0, 0, 1, 32'h40, 1, 32'h20, 0);
    cyc(1, 32'h40, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    cyc(1, 32'h140, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    cyc(0, 32'h0, 0, 0, 0, 1, 32'h140, 0, 32'h0, 1);
    cyc(1, 32'h140, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    cyc(0, 32'h0, 0, 0, 0, 1, 32'h140, 1, 32'h33, 0);
    cyc(0, 32'h0, 0, 0, 0, 1, 32'h140, 1, 32'h33, 0);
    cyc(1, 32'h140, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    cyc(1, 32'h40, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0);

    // Same-cycle lookup and update on one slot, then the following cycle
    cyc(1, 32'h140, 1, 0, 0, 1, 32'h140, 0, 32'h0, 1);
    cyc(1, 32'h140, 1, 0, 0, 1, 32'h140, 0, 32'h0, 1);
    cyc(1, 32'h140, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0);

    // Return stack: train the ret slot, 9 calls, 9 rets (last falls back)
    cyc(0, 32'h0, 0, 0, 0, 1, 32'h200, 1, 32'h77, 0);
    cyc(0, 32'h0, 0, 0, 0, 1, 32'h200, 1, 32'h77, 0);
    for (int i = 0; i < 9; i++) cyc(1, 32'h100 + i, 1, 1, 0, 0, 32'h0, 0, 32'h0, 0);
    for (int i = 0; i < 9; i++) cyc(1, 32'h200, 1, 0, 1, 0, 32'h0, 0, 32'h0, 0);
    // call/ret without lk_valid are no-ops; then same-cycle call+ret
    cyc(0, 32'h300, 1, 1, 1, 0, 32'h0, 0, 32'h0, 0);
    cyc(1, 32'h310, 1, 1, 0, 0, 32'h0, 0, 32'h0, 0);
    cyc(1, 32'h320, 1, 1, 1, 0, 32'h0, 0, 32'h0, 0);
    cyc(1, 32'h200, 1, 0, 1, 0, 32'h0, 0, 32'h0, 0);
    cyc(1, 32'h200, 1, 0, 1, 0, 32'h0, 0, 32'h0, 0);

    // Random run phase
    for (int i = 0; i < 400; i++) rnd_cyc();

    // Reset mid-INIT: clearing restarts and runs a full table again
    do_reset(2);
    for (int i = 0; i < 100; i++) rnd_cyc();
    do_reset(1);
    for (int i = 0; i < ENTRIES + 40; i++) rnd_cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
